// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package rom_fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo
  import rom_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the async ROM, buffers returned words and
// hands them to decode over valid/ready, with redirect, halt and fault handling.
module rom_fetch_ctrl
  import rom_fetch_pkg::*;
#(
  parameter int unsigned TAM_POSICIONES = 1024,
  parameter int unsigned TAM_PALABRA    = 32,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  output logic                              ROM_CE,
  output logic                              ROM_READ_EN,
  output logic [$clog2(TAM_POSICIONES)-1:0] ROM_ADDR,
  input  logic [TAM_PALABRA-1:0]            ROM_DATA,
  output logic                              INS_VALID,
  input  logic                              INS_READY,
  output logic [TAM_PALABRA-1:0]            INS_DATA,
  output logic [31:0]                       INS_PC,
  input  logic                              REDIRECT_EN,
  input  logic [31:0]                       REDIRECT_PC,
  input  logic                              HALT_REQ,
  output logic                              FETCH_ERR,
  output logic                              BUSY
);

  localparam int unsigned ADDR_W   = $clog2(TAM_POSICIONES);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] PC_LIMIT = 33'(TAM_POSICIONES) << 2;

  typedef struct packed {
    logic [TAM_PALABRA-1:0] instr;
    logic [31:0]            pc;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  entry_t            push_entry, head;
  logic              fifo_full, fifo_empty, flush, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              room, want_issue, in_range, issue, misaligned;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .push_i  (issue),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign INS_VALID  = !fifo_empty && (state_q != FAULT);
  assign pop        = INS_VALID && INS_READY;
  assign room       = (fifo_count < CNT_W'(FIFO_DEPTH)) || (fifo_full && pop);
  assign want_issue = (state_q == RUN) && !REDIRECT_EN && !HALT_REQ && room;
  assign in_range   = {1'b0, pc_q} < PC_LIMIT;
  assign issue      = want_issue && in_range;
  assign misaligned = (REDIRECT_PC[1:0] != 2'b00);
  assign push_entry = '{instr: ROM_DATA, pc: pc_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    flush   = 1'b0;
    // Redirect outranks halt and issue in every live state; FAULT ignores everything.
    case (state_q)
      IDLE: begin
        if (REDIRECT_EN) begin
          flush = 1'b1;
          if (misaligned) state_d = FAULT;
          else begin
            pc_d    = REDIRECT_PC;
            state_d = RUN;
          end
        end else begin
          state_d = HALT_REQ ? HALT : RUN;
        end
      end
      RUN: begin
        if (REDIRECT_EN) begin
          flush = 1'b1;
          if (misaligned) state_d = FAULT;
          else            pc_d    = REDIRECT_PC;
        end else if (HALT_REQ) begin
          state_d = HALT;
        end else if (want_issue && !in_range) begin
          state_d = FAULT;
        end else if (issue) begin
          pc_d   = pc_q + PC_STEP;
          addr_d = pc_q[ADDR_W+1:2];
        end
      end
      HALT: begin
        if (REDIRECT_EN) begin
          flush = 1'b1;
          if (misaligned) state_d = FAULT;
          else            pc_d    = REDIRECT_PC;
        end else if (!HALT_REQ) begin
          state_d = RUN;
        end
      end
      default: flush = 1'b1;
    endcase
    if (state_d == FAULT) flush = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign ROM_CE      = issue;
  assign ROM_READ_EN = issue;
  assign ROM_ADDR    = issue ? pc_q[ADDR_W+1:2] : addr_q;
  assign INS_DATA    = head.instr;
  assign INS_PC      = head.pc;
  assign FETCH_ERR   = (state_q == FAULT);
  assign BUSY        = (state_q == RUN);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl: a scoreboard checks every accepted instruction,
// the stimulus thread checks ROM strobes, addresses and status flags per cycle.
module tb_rom_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N, INS_READY, REDIRECT_EN, HALT_REQ;
  logic [31:0] REDIRECT_PC;
  logic        ROM_CE, ROM_READ_EN, INS_VALID, FETCH_ERR, BUSY;
  logic [9:0]  ROM_ADDR;
  logic [31:0] ROM_DATA, INS_DATA, INS_PC;

  logic        RESET_N_S, INS_READY_S, REDIRECT_EN_S;
  logic [31:0] REDIRECT_PC_S;
  logic        ROM_CE_S, ROM_READ_EN_S, INS_VALID_S, FETCH_ERR_S, BUSY_S;
  logic [3:0]  ROM_ADDR_S;
  logic [31:0] ROM_DATA_S, INS_DATA_S, INS_PC_S;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  exp_t        exp_q[$];

  always #5 CLK = ~CLK;

  assign ROM_DATA   = 32'h1000_0000 + 32'(ROM_ADDR);
  assign ROM_DATA_S = 32'h1000_0000 + 32'(ROM_ADDR_S);

  rom_fetch_ctrl #(
    .TAM_POSICIONES (1024),
    .TAM_PALABRA    (32),
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (2)
  ) dut (
    .CLK (CLK), .RESET_N (RESET_N),
    .ROM_CE (ROM_CE), .ROM_READ_EN (ROM_READ_EN), .ROM_ADDR (ROM_ADDR), .ROM_DATA (ROM_DATA),
    .INS_VALID (INS_VALID), .INS_READY (INS_READY), .INS_DATA (INS_DATA), .INS_PC (INS_PC),
    .REDIRECT_EN (REDIRECT_EN), .REDIRECT_PC (REDIRECT_PC), .HALT_REQ (HALT_REQ),
    .FETCH_ERR (FETCH_ERR), .BUSY (BUSY)
  );

  rom_fetch_ctrl #(
    .TAM_POSICIONES (16),
    .TAM_PALABRA    (32),
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (2)
  ) dut_s (
    .CLK (CLK), .RESET_N (RESET_N_S),
    .ROM_CE (ROM_CE_S), .ROM_READ_EN (ROM_READ_EN_S), .ROM_ADDR (ROM_ADDR_S), .ROM_DATA (ROM_DATA_S),
    .INS_VALID (INS_VALID_S), .INS_READY (INS_READY_S), .INS_DATA (INS_DATA_S), .INS_PC (INS_PC_S),
    .REDIRECT_EN (REDIRECT_EN_S), .REDIRECT_PC (REDIRECT_PC_S), .HALT_REQ (1'b0),
    .FETCH_ERR (FETCH_ERR_S), .BUSY (BUSY_S)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic expect_ins(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: every accepted head must match the next expected entry.
  always @(negedge CLK) begin
    if (RESET_N && INS_VALID && INS_READY && !REDIRECT_EN) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pc", INS_PC, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", INS_PC, e.pc);
        chk("sb_data", INS_DATA, e.instr);
      end
    end
  end

  initial begin
    RESET_N = 1'b0; INS_READY = 1'b0; REDIRECT_EN = 1'b0; HALT_REQ = 1'b0; REDIRECT_PC = '0;
    RESET_N_S = 1'b0; INS_READY_S = 1'b0; REDIRECT_EN_S = 1'b0; REDIRECT_PC_S = '0;

    step(); #1;
    chk("rst_valid", INS_VALID, 0); chk("rst_ce", ROM_CE, 0);
    chk("rst_err", FETCH_ERR, 0);   chk("rst_busy", BUSY, 0);

    // Decode stalled for 5 cycles: exactly two fetches fill the FIFO.
    step(); RESET_N = 1'b1; #1;
    chk("c0_ce", ROM_CE, 0);
    expect_ins(32'h0, 32'h1000_0000);
    expect_ins(32'h4, 32'h1000_0001);
    expect_ins(32'h8, 32'h1000_0002);
    step(); #1;
    chk("c1_ce", ROM_CE, 1); chk("c1_rd", ROM_READ_EN, 1); chk("c1_addr", ROM_ADDR, 0);
    chk("c1_valid", INS_VALID, 0); chk("c1_busy", BUSY, 1);
    step(); #1;
    chk("c2_valid", INS_VALID, 1); chk("c2_pc", INS_PC, 0); chk("c2_addr", ROM_ADDR, 1);
    step(); #1;
    chk("c3_ce", ROM_CE, 0); chk("c3_addr_hold", ROM_ADDR, 1);
    chk("c3_pc", INS_PC, 0); chk("c3_data", INS_DATA, 32'h1000_0000);
    step(); #1;
    chk("c4_ce", ROM_CE, 0); chk("c4_pc", INS_PC, 0);

    // Decode resumes: one pop plus one push per cycle.
    step(); INS_READY = 1'b1; #1;
    chk("c5_ce", ROM_CE, 1); chk("c5_addr", ROM_ADDR, 2);
    step(); #1;
    chk("c6_pc", INS_PC, 4); chk("c6_addr", ROM_ADDR, 3);
    step(); #1;
    chk("c7_addr", ROM_ADDR, 4);

    // Redirect with a full FIFO.
    step(); INS_READY = 1'b0; REDIRECT_EN = 1'b1; REDIRECT_PC = 32'h40; #1;
    chk("c8_ce", ROM_CE, 0);
    step(); REDIRECT_EN = 1'b0; #1;
    chk("c9_valid", INS_VALID, 0); chk("c9_ce", ROM_CE, 1); chk("c9_addr", ROM_ADDR, 16);
    expect_ins(32'h40, 32'h1000_0010);
    expect_ins(32'h44, 32'h1000_0011);
    step(); #1;
    chk("c10_valid", INS_VALID, 1); chk("c10_pc", INS_PC, 32'h40);

    // Halt for 4 cycles while the FIFO drains.
    step(); INS_READY = 1'b1; HALT_REQ = 1'b1; #1;
    chk("c11_ce", ROM_CE, 0);
    step(); #1;
    chk("c12_ce", ROM_CE, 0); chk("c12_busy", BUSY, 0);
    step(); #1;
    chk("c13_valid", INS_VALID, 0);
    step(); #1;
    chk("c14_ce", ROM_CE, 0); chk("c14_busy", BUSY, 0);
    step(); HALT_REQ = 1'b0; #1;
    chk("c15_ce", ROM_CE, 0);
    expect_ins(32'h48, 32'h1000_0012);
    expect_ins(32'h4C, 32'h1000_0013);
    step(); #1;
    chk("c16_ce", ROM_CE, 1); chk("c16_addr", ROM_ADDR, 18); chk("c16_busy", BUSY, 1);
    step(); #1;
    chk("c17_addr", ROM_ADDR, 19);
    step(); #1;
    chk("c18_addr", ROM_ADDR, 20);

    // Misaligned redirect faults until reset.
    step(); REDIRECT_EN = 1'b1; REDIRECT_PC = 32'h42; #1;
    step(); REDIRECT_EN = 1'b0; #1;
    chk("f0_err", FETCH_ERR, 1); chk("f0_valid", INS_VALID, 0);
    chk("f0_ce", ROM_CE, 0); chk("f0_busy", BUSY, 0);
    step(); step(); #1;
    chk("f2_err", FETCH_ERR, 1); chk("f2_valid", INS_VALID, 0);
    RESET_N = 1'b0; #1;
    chk("f_rst_err", FETCH_ERR, 0); chk("f_rst_valid", INS_VALID, 0);
    step(); RESET_N = 1'b1;
    expect_ins(32'h0, 32'h1000_0000);
    expect_ins(32'h4, 32'h1000_0001);
    step(); #1;
    chk("r1_ce", ROM_CE, 1); chk("r1_addr", ROM_ADDR, 0); chk("r1_err", FETCH_ERR, 0);
    step(); step();
    step(); INS_READY = 1'b0; #1;
    chk("sb_drained", 32'(exp_q.size()), 0);

    // Small ROM: words 14 and 15 delivered, then fault instead of fetching 0x40.
    step(); RESET_N_S = 1'b1; REDIRECT_EN_S = 1'b1; REDIRECT_PC_S = 32'h38; INS_READY_S = 1'b1; #1;
    chk("s0_ce", ROM_CE_S, 0);
    step(); REDIRECT_EN_S = 1'b0; #1;
    chk("s1_ce", ROM_CE_S, 1); chk("s1_addr", ROM_ADDR_S, 14);
    step(); #1;
    chk("s2_valid", INS_VALID_S, 1); chk("s2_pc", INS_PC_S, 32'h38);
    chk("s2_data", INS_DATA_S, 32'h1000_000E); chk("s2_addr", ROM_ADDR_S, 15);
    step(); #1;
    chk("s3_pc", INS_PC_S, 32'h3C); chk("s3_data", INS_DATA_S, 32'h1000_000F);
    chk("s3_ce", ROM_CE_S, 0);
    step(); #1;
    chk("s4_err", FETCH_ERR_S, 1); chk("s4_valid", INS_VALID_S, 0); chk("s4_ce", ROM_CE_S, 0);
    RESET_N_S = 1'b0;
    step(); RESET_N_S = 1'b1;
    step(); #1;
    chk("s_r1_ce", ROM_CE_S, 1); chk("s_r1_addr", ROM_ADDR_S, 0);
    RESET_N_S = 1'b0; #1;
    chk("s_rst_ce", ROM_CE_S, 0); chk("s_rst_valid", INS_VALID_S, 0); chk("s_rst_busy", BUSY_S, 0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
